exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have parameter DIV_STEPS, default 32, meaning the number of divider iterations, one quotient bit per cycle.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port valid_i, input, 1 bit: ID presents an instruction this cycle.
REQ-005 The block SHALL have port aluOp_i, input, 5 bits: operation code, from the shared package.
REQ-006 The block SHALL have ports op1_i and op2_i, input, 32 bits each: source operands; op2_i is already immediate-selected.
REQ-007 The block SHALL have ports memData_i (input, 32 bits: store data), regcAddr_i (input, 5 bits), regcWr_i (input, 1 bit), memWr_i (input, 1 bit), memRr_i (input, 1 bit), w_mask_i (input, 4 bits) and r_mask_i (input, 4 bits), all passed toward MEM.
REQ-008 The block SHALL have outputs regcData (32), regcAddr (5), regcWr (1), memAddr (32), memData (32), memWr (1), memRr (1), w_mask (4) and r_mask (4), all combinational, consumed by MEM's input register.
REQ-009 The block SHALL have port stall, output, 1 bit: ID must hold its instruction and re-present it next cycle.

Function
REQ-010 Accept: the block SHALL treat an instruction as accepted when valid_i=1 and stall=0.
REQ-011 Bubble: whenever valid_i=0 or stall=1, the block SHALL drive regcWr, memWr and memRr to 0 and w_mask and r_mask to 0.
REQ-012 Single-cycle ops: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA and LUI SHALL produce regcData in the same cycle; arithmetic is modulo 2^32 with no overflow trap; shifts use op1_i[4:0].
REQ-013 Loads and stores: when memRr_i or memWr_i is set, memAddr SHALL equal op1_i+op2_i regardless of aluOp_i, and memData SHALL equal memData_i.
REQ-014 MULT/MULTU: on accept, the block SHALL write the 64-bit signed or unsigned product to HI:LO at the next edge.
REQ-015 MTHI/MTLO: on accept, the block SHALL write op1_i to HI or LO at the next edge.
REQ-016 MFHI/MFLO: regcData SHALL equal the current HI or LO.
REQ-017 DIV/DIVU, FSM states: IDLE, BUSY.
REQ-018 DIV/DIVU, start: an accepted DIV/DIVU SHALL move the FSM from IDLE to BUSY, latch the operand magnitudes and sign flags, and clear the step counter.
REQ-019 DIV/DIVU, stepping: in BUSY, each edge SHALL perform one restoring step; after step DIV_STEPS the block SHALL write quotient to LO and remainder to HI, and the FSM SHALL return to IDLE.
REQ-020 DIV/DIVU, latency: an instruction accepted at edge N SHALL have HI/LO updated at edge N+32.
REQ-021 DIV signed results: the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero SHALL NOT stall beyond normal latency; DIVU SHALL give LO=0xFFFFFFFF and HI=dividend; DIV SHALL apply the sign fix to those values.
REQ-023 HI/LO interlock: while BUSY, stall SHALL be 1 iff valid_i=1 and aluOp_i is MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI or MTLO.
REQ-024 While BUSY, all other instructions SHALL proceed without stall.
REQ-025 In the cycle the FSM returns to IDLE, a held HI/LO instruction SHALL still stall; it SHALL be accepted the following cycle and observe the new HI/LO.
REQ-026 stall SHALL depend only on registered state and the current inputs, with no combinational path from its own output.

Reset
REQ-027 While rst=0, the FSM SHALL be IDLE, HI, LO and the divider registers SHALL be 0, and stall SHALL be 0.
REQ-028 Reset asserted mid-division SHALL abort it and leave no HI/LO update after release.
REQ-029 On rst release, the first edge SHALL be able to accept an instruction.

Structure
REQ-030 The aluOp encodings, the FSM state encoding and DIV_STEPS SHALL live in the shared cpu package, which ID also imports.
REQ-031 The iterative divider (FSM, counter, remainder and quotient registers, sign fix) SHALL be sub-module exe_div with start, done and busy handshake.
REQ-032 ALU, multiplier and HI/LO SHALL stay in exe_stage.

Verification
REQ-033 The bench SHALL check: ADD, op1=0x7FFFFFFF, op2=1, regcAddr=5, regcWr=1 -> same cycle regcData=0x80000000, regcWr=1, regcAddr=5.
REQ-034 The bench SHALL check: load with op1=0x1000, op2=0xFFFFFFFC, r_mask=0xF -> memAddr=0x00000FFC, memRr=1, r_mask=0xF.
REQ-035 The bench SHALL check: DIV -7/2 accepted at edge N, then MFLO presented -> stall=1 through the FSM return cycle, LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1) at edge N+32, and MFLO completes with regcData=0xFFFFFFFD.
REQ-036 The bench SHALL check: DIVU 100/0 -> LO=0xFFFFFFFF and HI=100 after 32 cycles.
REQ-037 The bench SHALL check: DIVU busy, then ADD and SW presented -> no stall, and outputs are correct in the same cycle.
REQ-038 The bench SHALL check: MULT 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; and rst=0 at step 10 of a DIV -> HI=LO=0, stall=0, FSM IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU operation codes, divider FSM encoding and
// divider step count, imported by both ID and EXE.
package cpu_pkg;

  localparam int DIV_STEPS = 32;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_ADD   = 5'd1,
    OP_SUB   = 5'd2,
    OP_AND   = 5'd3,
    OP_OR    = 5'd4,
    OP_XOR   = 5'd5,
    OP_NOR   = 5'd6,
    OP_SLT   = 5'd7,
    OP_SLTU  = 5'd8,
    OP_SLL   = 5'd9,
    OP_SRL   = 5'd10,
    OP_SRA   = 5'd11,
    OP_LUI   = 5'd12,
    OP_MULT  = 5'd13,
    OP_MULTU = 5'd14,
    OP_DIV   = 5'd15,
    OP_DIVU  = 5'd16,
    OP_MFHI  = 5'd17,
    OP_MFLO  = 5'd18,
    OP_MTHI  = 5'd19,
    OP_MTLO  = 5'd20
  } alu_op_e;

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_BUSY = 1'b1
  } div_state_e;

  // Operations that read or write HI/LO and therefore collide with a running divide.
  function automatic logic is_hilo_op(alu_op_e op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO};
  endfunction

  function automatic logic [31:0] magnitude(logic [31:0] x, logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/exe_div.sv
// Iterative restoring divider, one quotient bit per cycle, with sign fix-up.
// done_o pulses combinationally during the final step alongside the result.
module exe_div
  import cpu_pkg::*;
#(
  parameter int STEPS = DIV_STEPS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  localparam int CNT_W = $clog2(STEPS + 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rem_q, rem_d;
  logic [31:0]      quo_q, quo_d;
  logic [31:0]      dvsr_q, dvsr_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [32:0]      rem_sh;
  logic             take;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    done_o  = 1'b0;
    rem_sh  = {rem_q, quo_q[31]};
    take    = (rem_sh >= {1'b0, dvsr_q});

    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = magnitude(dividend_i, signed_i);
          dvsr_d  = magnitude(divisor_i, signed_i);
          qneg_d  = signed_i & (dividend_i[31] ^ divisor_i[31]);
          rneg_d  = signed_i & dividend_i[31];
        end
      end
      DIV_BUSY: begin
        // A zero divisor always "fits", giving all-ones quotient and dividend remainder.
        rem_d = take ? 32'(rem_sh - {1'b0, dvsr_q}) : rem_sh[31:0];
        quo_d = {quo_q[30:0], take};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(STEPS - 1)) begin
          done_o  = 1'b1;
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; all datapath registers are reset
  // so an aborted divide leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy_o = (state_q == DIV_BUSY);
  assign quo_o  = qneg_q ? -quo_d : quo_d;
  assign rem_o  = rneg_q ? -rem_d : rem_d;

endmodule

// File: rtl/exe_stage.sv
// Execute stage: single-cycle ALU, multiplier, HI/LO registers and the
// iterative divider, with a HI/LO interlock toward ID while dividing.
module exe_stage
  import cpu_pkg::*;
#(
  parameter int DIV_STEPS = cpu_pkg::DIV_STEPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [4:0]  aluOp_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic [31:0] memData_i,
  input  logic [4:0]  regcAddr_i,
  input  logic        regcWr_i,
  input  logic        memWr_i,
  input  logic        memRr_i,
  input  logic [3:0]  w_mask_i,
  input  logic [3:0]  r_mask_i,
  output logic [31:0] regcData,
  output logic [4:0]  regcAddr,
  output logic        regcWr,
  output logic [31:0] memAddr,
  output logic [31:0] memData,
  output logic        memWr,
  output logic        memRr,
  output logic [3:0]  w_mask,
  output logic [3:0]  r_mask,
  output logic        stall
);

  alu_op_e     op;
  logic        accept;
  logic        div_busy, div_done, div_start;
  logic [31:0] div_quo, div_rem;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] mul_s, mul_u;

  assign op     = alu_op_e'(aluOp_i);
  // Only registered divider state and current inputs feed stall.
  assign stall  = div_busy & valid_i & is_hilo_op(op);
  assign accept = valid_i & ~stall;

  assign div_start = accept & ((op == OP_DIV) | (op == OP_DIVU));

  exe_div #(.STEPS(DIV_STEPS)) u_div (
    .clk        (clk),
    .rst_n      (rst),
    .start_i    (div_start),
    .signed_i   (op == OP_DIV),
    .dividend_i (op1_i),
    .divisor_i  (op2_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  assign mul_s = $signed({{32{op1_i[31]}}, op1_i}) * $signed({{32{op2_i[31]}}, op2_i});
  assign mul_u = {32'b0, op1_i} * {32'b0, op2_i};

  always_comb begin
    regcData = '0;
    case (op)
      OP_ADD:  regcData = op1_i + op2_i;
      OP_SUB:  regcData = op1_i - op2_i;
      OP_AND:  regcData = op1_i & op2_i;
      OP_OR:   regcData = op1_i | op2_i;
      OP_XOR:  regcData = op1_i ^ op2_i;
      OP_NOR:  regcData = ~(op1_i | op2_i);
      OP_SLT:  regcData = {31'b0, $signed(op1_i) < $signed(op2_i)};
      OP_SLTU: regcData = {31'b0, op1_i < op2_i};
      OP_SLL:  regcData = op2_i << op1_i[4:0];
      OP_SRL:  regcData = op2_i >> op1_i[4:0];
      OP_SRA:  regcData = $signed(op2_i) >>> op1_i[4:0];
      OP_LUI:  regcData = {op2_i[15:0], 16'h0000};
      OP_MFHI: regcData = hi_q;
      OP_MFLO: regcData = lo_q;
      default: regcData = '0;
    endcase
  end

  // The divider and HI/LO instructions cannot both fire: the latter stall while busy.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_done) begin
      hi_d = div_rem;
      lo_d = div_quo;
    end else if (accept) begin
      case (op)
        OP_MULT:  {hi_d, lo_d} = mul_s;
        OP_MULTU: {hi_d, lo_d} = mul_u;
        OP_MTHI:  hi_d = op1_i;
        OP_MTLO:  lo_d = op1_i;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign regcAddr = regcAddr_i;
  assign regcWr   = accept & regcWr_i;
  assign memAddr  = op1_i + op2_i;
  assign memData  = memData_i;
  assign memWr    = accept & memWr_i;
  assign memRr    = accept & memRr_i;
  assign w_mask   = accept ? w_mask_i : 4'h0;
  assign r_mask   = accept ? r_mask_i : 4'h0;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor compares each accepted instruction.
module tb_exe_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [4:0]  aluOp_i;
  logic [31:0] op1_i, op2_i, memData_i;
  logic [4:0]  regcAddr_i;
  logic        regcWr_i, memWr_i, memRr_i;
  logic [3:0]  w_mask_i, r_mask_i;
  logic [31:0] regcData, memAddr, memData;
  logic [4:0]  regcAddr;
  logic        regcWr, memWr, memRr, stall;
  logic [3:0]  w_mask, r_mask;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       name;
    logic        chk_data;
    logic [31:0] data;
    logic        wr;
    logic [4:0]  addr;
    logic        chk_mem;
    logic [31:0] maddr;
    logic [31:0] mdata;
    logic        mwr;
    logic        mrr;
    logic [3:0]  wm;
    logic [3:0]  rm;
  } exp_t;

  exp_t sb[$];

  exe_stage dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .aluOp_i    (aluOp_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .memData_i  (memData_i),
    .regcAddr_i (regcAddr_i),
    .regcWr_i   (regcWr_i),
    .memWr_i    (memWr_i),
    .memRr_i    (memRr_i),
    .w_mask_i   (w_mask_i),
    .r_mask_i   (r_mask_i),
    .regcData   (regcData),
    .regcAddr   (regcAddr),
    .regcWr     (regcWr),
    .memAddr    (memAddr),
    .memData    (memData),
    .memWr      (memWr),
    .memRr      (memRr),
    .w_mask     (w_mask),
    .r_mask     (r_mask),
    .stall      (stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted instruction must match the oldest scoreboard entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && valid_i && !stall) begin
        if (sb.size() == 0) begin
          check("unexpected_accept", 64'(aluOp_i), 64'h1F);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (e.chk_data) check({e.name, "_regcData"}, 64'(regcData), 64'(e.data));
          check({e.name, "_regcWr"},   64'(regcWr),   64'(e.wr));
          check({e.name, "_regcAddr"}, 64'(regcAddr), 64'(e.addr));
          check({e.name, "_memWr"},    64'(memWr),    64'(e.mwr));
          check({e.name, "_memRr"},    64'(memRr),    64'(e.mrr));
          if (e.chk_mem) begin
            check({e.name, "_memAddr"}, 64'(memAddr), 64'(e.maddr));
            check({e.name, "_memData"}, 64'(memData), 64'(e.mdata));
            check({e.name, "_w_mask"},  64'(w_mask),  64'(e.wm));
            check({e.name, "_r_mask"},  64'(r_mask),  64'(e.rm));
          end
        end
      end
    end
  end

  task automatic set_in(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] ra, input logic rw, input logic mr, input logic mw,
                        input logic [31:0] md, input logic [3:0] wm, input logic [3:0] rm);
    valid_i = 1'b1; aluOp_i = op; op1_i = a; op2_i = b; regcAddr_i = ra; regcWr_i = rw;
    memRr_i = mr; memWr_i = mw; memData_i = md; w_mask_i = wm; r_mask_i = rm;
  endtask

  // Hold the presented instruction until accepted; bounded so a stuck stall cannot hang.
  task automatic wait_accept(input string nm, input logic must_not_stall);
    int n;
    n = 0;
    @(negedge clk);
    if (must_not_stall) check({nm, "_nostall"}, 64'(stall), 64'h0);
    while (stall) begin
      n++;
      if (n >= 100) begin
        n_checks++;
        n_errors++;
        $display("FAIL %s_timeout: stall still 1 after %0d cycles, required release", nm, n);
        void'(sb.pop_back());
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic alu(input string nm, input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] ra, input logic [31:0] exp_d,
                     input logic must_not_stall);
    exp_t e;
    set_in(op, a, b, ra, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
    e = '{name: nm, chk_data: 1'b1, data: exp_d, wr: 1'b1, addr: ra, chk_mem: 1'b0,
          maddr: 32'h0, mdata: 32'h0, mwr: 1'b0, mrr: 1'b0, wm: 4'h0, rm: 4'h0};
    sb.push_back(e);
    wait_accept(nm, must_not_stall);
  endtask

  task automatic hilo_wr(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    exp_t e;
    set_in(op, a, b, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
    e = '{name: nm, chk_data: 1'b0, data: 32'h0, wr: 1'b0, addr: 5'd0, chk_mem: 1'b0,
          maddr: 32'h0, mdata: 32'h0, mwr: 1'b0, mrr: 1'b0, wm: 4'h0, rm: 4'h0};
    sb.push_back(e);
    wait_accept(nm, 1'b0);
  endtask

  // Start a divide, then present MFLO at once: it must stall exactly DIV_STEPS cycles.
  task automatic div_read(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi);
    exp_t e;
    int   st;
    hilo_wr({nm, "_start"}, op, a, b);
    set_in(OP_MFLO, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
    e = '{name: {nm, "_mflo"}, chk_data: 1'b1, data: exp_lo, wr: 1'b1, addr: 5'd9,
          chk_mem: 1'b0, maddr: 32'h0, mdata: 32'h0, mwr: 1'b0, mrr: 1'b0, wm: 4'h0, rm: 4'h0};
    sb.push_back(e);
    st = 0;
    @(negedge clk);
    check({nm, "_bubble_regcWr"}, 64'(regcWr), 64'h0);
    while (stall && st < 100) begin
      st++;
      @(negedge clk);
    end
    check({nm, "_stall_cycles"}, 64'(st), 64'd32);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    alu({nm, "_mfhi"}, OP_MFHI, 32'h0, 32'h0, 5'd10, exp_hi, 1'b1);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0;
    set_in(OP_MFLO, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    check("reset_stall", 64'(stall), 64'h0);
    check("reset_lo", 64'(regcData), 64'h0);

    set_in(OP_ADD, 32'h1, 32'h2, 5'd3, 1'b1, 1'b1, 1'b1, 32'h5, 4'h5, 4'hA);
    valid_i = 1'b0;
    #1;
    check("bubble_regcWr", 64'(regcWr), 64'h0);
    check("bubble_memWr",  64'(memWr),  64'h0);
    check("bubble_memRr",  64'(memRr),  64'h0);
    check("bubble_w_mask", 64'(w_mask), 64'h0);
    check("bubble_r_mask", 64'(r_mask), 64'h0);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    alu("add_ovf", OP_ADD,  32'h7FFFFFFF, 32'h1,        5'd5, 32'h80000000, 1'b1);
    alu("sub",     OP_SUB,  32'd5,        32'd7,        5'd3, 32'hFFFFFFFE, 1'b1);
    alu("and",     OP_AND,  32'hF0F0,     32'hFF00,     5'd4, 32'h0000F000, 1'b1);
    alu("or",      OP_OR,   32'hF0F0,     32'h0F0F,     5'd4, 32'h0000FFFF, 1'b1);
    alu("xor",     OP_XOR,  32'hFFFF,     32'h00FF,     5'd4, 32'h0000FF00, 1'b1);
    alu("nor",     OP_NOR,  32'h0,        32'h0,        5'd6, 32'hFFFFFFFF, 1'b1);
    alu("slt",     OP_SLT,  32'hFFFFFFFF, 32'h1,        5'd7, 32'h1,        1'b1);
    alu("sltu",    OP_SLTU, 32'hFFFFFFFF, 32'h1,        5'd7, 32'h0,        1'b1);
    alu("sll",     OP_SLL,  32'h4,        32'h1,        5'd8, 32'h10,       1'b1);
    alu("srl",     OP_SRL,  32'h4,        32'h80000000, 5'd8, 32'h08000000, 1'b1);
    alu("sra",     OP_SRA,  32'h4,        32'h80000000, 5'd8, 32'hF8000000, 1'b1);
    alu("lui",     OP_LUI,  32'h0,        32'h1234,     5'd9, 32'h12340000, 1'b1);

    set_in(OP_ADD, 32'h1000, 32'hFFFFFFFC, 5'd8, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 4'hF);
    e = '{name: "load", chk_data: 1'b0, data: 32'h0, wr: 1'b1, addr: 5'd8, chk_mem: 1'b1,
          maddr: 32'h00000FFC, mdata: 32'h0, mwr: 1'b0, mrr: 1'b1, wm: 4'h0, rm: 4'hF};
    sb.push_back(e);
    wait_accept("load", 1'b1);

    hilo_wr("mult", OP_MULT, 32'hFFFFFFFF, 32'h2);
    alu("mult_hi", OP_MFHI, 32'h0, 32'h0, 5'd2, 32'hFFFFFFFF, 1'b1);
    alu("mult_lo", OP_MFLO, 32'h0, 32'h0, 5'd2, 32'hFFFFFFFE, 1'b1);
    hilo_wr("multu", OP_MULTU, 32'hFFFFFFFF, 32'h2);
    alu("multu_hi", OP_MFHI, 32'h0, 32'h0, 5'd2, 32'h00000001, 1'b1);
    alu("multu_lo", OP_MFLO, 32'h0, 32'h0, 5'd2, 32'hFFFFFFFE, 1'b1);
    hilo_wr("mthi", OP_MTHI, 32'h11, 32'h0);
    hilo_wr("mtlo", OP_MTLO, 32'h22, 32'h0);
    alu("mthi_rd", OP_MFHI, 32'h0, 32'h0, 5'd2, 32'h11, 1'b1);
    alu("mtlo_rd", OP_MFLO, 32'h0, 32'h0, 5'd2, 32'h22, 1'b1);

    div_read("div_m7_2",   OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    div_read("divu_100_0", OP_DIVU, 32'd100,      32'd0, 32'hFFFFFFFF, 32'd100);
    div_read("div_m9_0",   OP_DIV,  32'hFFFFFFF7, 32'd0, 32'h00000001, 32'hFFFFFFF7);

    hilo_wr("divu_50_7", OP_DIVU, 32'd50, 32'd7);
    alu("busy_add", OP_ADD, 32'd3, 32'd4, 5'd12, 32'd7, 1'b1);
    set_in(OP_ADD, 32'h2000, 32'h4, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 4'h3, 4'h0);
    e = '{name: "busy_sw", chk_data: 1'b0, data: 32'h0, wr: 1'b0, addr: 5'd0, chk_mem: 1'b1,
          maddr: 32'h00002004, mdata: 32'hDEADBEEF, mwr: 1'b1, mrr: 1'b0, wm: 4'h3, rm: 4'h0};
    sb.push_back(e);
    wait_accept("busy_sw", 1'b1);
    alu("divu_50_7_lo", OP_MFLO, 32'h0, 32'h0, 5'd2, 32'd7, 1'b0);
    alu("divu_50_7_hi", OP_MFHI, 32'h0, 32'h0, 5'd2, 32'd1, 1'b1);

    hilo_wr("div_abort", OP_DIV, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b0;
    set_in(OP_MFLO, 32'h0, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 4'h0);
    #1;
    check("abort_stall", 64'(stall), 64'h0);
    check("abort_lo", 64'(regcData), 64'h0);
    aluOp_i = OP_MFHI;
    #1;
    check("abort_hi", 64'(regcData), 64'h0);
    valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    alu("post_abort_lo", OP_MFLO, 32'h0, 32'h0, 5'd2, 32'h0, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    alu("late_lo", OP_MFLO, 32'h0, 32'h0, 5'd2, 32'h0, 1'b1);
    alu("late_hi", OP_MFHI, 32'h0, 32'h0, 5'd2, 32'h0, 1'b1);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
